// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi: MM:SS BCD clock with NUM_ALARMS alarm channels, driven
// by ASCII commands from a UART receiver. Digits of a command are collected
// in a shadow register and only committed to the target on the closing CR.
// Optional snooze support ('s' command, SNOOZED state, per-alarm tick
// counters) is compiled in when the macro ALARM_SNOOZE_EN is defined.
module alarm_clock_multi #(
  parameter int NUM_ALARMS = 2,
  parameter int SNOOZE_SEC = 300
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      oneSecStrb,
  input  logic                      bu_rx_data_rdy,
  input  logic [7:0]                bu_rx_data,
  output logic [3:0]                di_Mtens,
  output logic [3:0]                di_Mones,
  output logic [3:0]                di_Stens,
  output logic [3:0]                di_Sones,
  output logic [16*NUM_ALARMS-1:0]  di_alarm,
  output logic [2*NUM_ALARMS-1:0]   alarm_state,
  output logic                      alarm_any_trig,
  output logic                      cmd_busy,
  output logic                      cmd_done,
  output logic                      cmd_err
);

  // Elaboration-time parameter range checks
  if (NUM_ALARMS < 1 || NUM_ALARMS > 8) begin : g_bad_num_alarms
    $error("alarm_clock_multi: NUM_ALARMS must be in 1..8");
  end
  if (SNOOZE_SEC < 1 || SNOOZE_SEC > 3599) begin : g_bad_snooze_sec
    $error("alarm_clock_multi: SNOOZE_SEC must be in 1..3599");
  end

  // Command characters
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_L    = 8'h6C;  // 'l' load time
  localparam logic [7:0] CH_A    = 8'h61;  // 'a' load alarm
  localparam logic [7:0] CH_AT   = 8'h40;  // '@' toggle alarm
`ifdef ALARM_SNOOZE_EN
  localparam logic [7:0] CH_S    = 8'h73;  // 's' snooze
`endif
  localparam logic [7:0] IDX_MAX = 8'(8'h30 + NUM_ALARMS - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_TL0, ST_TL1, ST_TL2, ST_TL3,
    ST_AIDX, ST_AL0, ST_AL1, ST_AL2, ST_AL3,
    ST_GIDX, ST_SEOL, ST_EOL
  } pstate_e;

  typedef enum logic [1:0] {
    CMD_TIME, CMD_ALARM, CMD_TOGGLE
  } cmd_e;

  typedef enum logic [1:0] {
    AL_OFF     = 2'b00,
    AL_ARMED   = 2'b01,
    AL_TRIG    = 2'b10,
    AL_SNOOZED = 2'b11
  } alarm_e;

  // Parser registers
  pstate_e     state_q, state_d;
  cmd_e        cmd_q, cmd_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] sh_q, sh_d;      // shadow {Mtens,Mones,Stens,Sones}
  logic        done_q, err_q;
  logic        commit, abort;

  // Timekeeping registers
  logic [15:0] time_q, time_d, time_inc;
  logic        tchg_q, tchg_d;  // time register took a new value last edge
  logic        run;

  // Commit decodes
  logic        time_load, alarm_load, toggle_cmd;
`ifdef ALARM_SNOOZE_EN
  logic        snooze_cmd;
`endif

  // Byte classification
  logic [3:0]  digit;
  logic        is_tens, is_ones, is_idx, is_cr;

  assign digit   = bu_rx_data[3:0];
  assign is_tens = (bu_rx_data >= 8'h30) && (bu_rx_data <= 8'h35);
  assign is_ones = (bu_rx_data >= 8'h30) && (bu_rx_data <= 8'h39);
  assign is_idx  = (bu_rx_data >= 8'h30) && (bu_rx_data <= IDX_MAX);
  assign is_cr   = (bu_rx_data == CH_CR);

  // Parser next state: capture digits into the shadow, decode commit/abort
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    commit  = 1'b0;
    abort   = 1'b0;
    if (bu_rx_data_rdy) begin
      case (state_q)
        ST_IDLE: begin
          // Anything unrecognised here, CR included, is silently dropped
          if (bu_rx_data == CH_L) begin
            state_d = ST_TL0;
            cmd_d   = CMD_TIME;
          end else if (bu_rx_data == CH_A) begin
            state_d = ST_AIDX;
            cmd_d   = CMD_ALARM;
          end else if (bu_rx_data == CH_AT) begin
            state_d = ST_GIDX;
            cmd_d   = CMD_TOGGLE;
          end
`ifdef ALARM_SNOOZE_EN
          else if (bu_rx_data == CH_S) begin
            state_d = ST_SEOL;
          end
`endif
        end
        ST_TL0: if (is_tens) begin sh_d[15:12] = digit; state_d = ST_TL1; end else abort = 1'b1;
        ST_TL1: if (is_ones) begin sh_d[11:8]  = digit; state_d = ST_TL2; end else abort = 1'b1;
        ST_TL2: if (is_tens) begin sh_d[7:4]   = digit; state_d = ST_TL3; end else abort = 1'b1;
        ST_TL3: if (is_ones) begin sh_d[3:0]   = digit; state_d = ST_EOL; end else abort = 1'b1;
        ST_AIDX: if (is_idx) begin idx_d = digit[2:0]; state_d = ST_AL0; end else abort = 1'b1;
        ST_AL0: if (is_tens) begin sh_d[15:12] = digit; state_d = ST_AL1; end else abort = 1'b1;
        ST_AL1: if (is_ones) begin sh_d[11:8]  = digit; state_d = ST_AL2; end else abort = 1'b1;
        ST_AL2: if (is_tens) begin sh_d[7:4]   = digit; state_d = ST_AL3; end else abort = 1'b1;
        ST_AL3: if (is_ones) begin sh_d[3:0]   = digit; state_d = ST_EOL; end else abort = 1'b1;
        ST_GIDX: if (is_idx) begin idx_d = digit[2:0]; state_d = ST_EOL; end else abort = 1'b1;
        ST_SEOL, ST_EOL: begin
          if (is_cr) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            abort = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
    end
  end

  // Parser state, shadow and one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_TIME;
      idx_q   <= '0;
      sh_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      done_q  <= commit;
      err_q   <= abort;
    end
  end

  assign time_load  = commit && (state_q == ST_EOL) && (cmd_q == CMD_TIME);
  assign alarm_load = commit && (state_q == ST_EOL) && (cmd_q == CMD_ALARM);
  assign toggle_cmd = commit && (state_q == ST_EOL) && (cmd_q == CMD_TOGGLE);
`ifdef ALARM_SNOOZE_EN
  assign snooze_cmd = commit && (state_q == ST_SEOL);
`endif

  // The clock is frozen only while time digits are being typed
  assign run = !(state_q inside {ST_TL0, ST_TL1, ST_TL2, ST_TL3});

  // Time one second on, with BCD carries and 59:59 wrapping to 00:00
  always_comb begin
    time_inc = '0;
    if (time_q[3:0] != 4'd9)
      time_inc = {time_q[15:4], time_q[3:0] + 4'd1};
    else if (time_q[7:4] != 4'd5)
      time_inc = {time_q[15:8], time_q[7:4] + 4'd1, 4'd0};
    else if (time_q[11:8] != 4'd9)
      time_inc = {time_q[15:12], time_q[11:8] + 4'd1, 8'd0};
    else if (time_q[15:12] != 4'd5)
      time_inc = {time_q[15:12] + 4'd1, 12'd0};
  end

  // Time next value: a committed load beats a same-cycle tick
  always_comb begin
    time_d = time_q;
    tchg_d = 1'b0;
    if (time_load) begin
      time_d = sh_q;
      tchg_d = 1'b1;
    end else if (oneSecStrb && run) begin
      time_d = time_inc;
      tchg_d = 1'b1;
    end
  end

  // Time register and fresh-value flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q <= '0;
      tchg_q <= 1'b0;
    end else begin
      time_q <= time_d;
      tchg_q <= tchg_d;
    end
  end

  assign {di_Mtens, di_Mones, di_Stens, di_Sones} = time_q;
  assign cmd_busy = (state_q != ST_IDLE);
  assign cmd_done = done_q;
  assign cmd_err  = err_q;

  // Alarm channels
  logic [NUM_ALARMS-1:0] trig_vec;

  for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
    logic [15:0] atime_q, atime_d;
    alarm_e      ast_q, ast_d;
    logic        sel;
`ifdef ALARM_SNOOZE_EN
    localparam int CNT_W = $clog2(SNOOZE_SEC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign sel = (idx_q == 3'(gi));

    // Alarm time reload and state transitions; commands outrank a match
    always_comb begin
      atime_d = atime_q;
      ast_d   = ast_q;
`ifdef ALARM_SNOOZE_EN
      cnt_d   = cnt_q;
`endif
      if (alarm_load && sel) atime_d = sh_q;
      if (toggle_cmd && sel) begin
        ast_d = (ast_q == AL_OFF) ? AL_ARMED : AL_OFF;
      end
`ifdef ALARM_SNOOZE_EN
      else if (snooze_cmd && (ast_q == AL_TRIG)) begin
        ast_d = AL_SNOOZED;
        cnt_d = '0;
      end else if ((ast_q == AL_SNOOZED) && oneSecStrb) begin
        // Counts even while the clock is frozen by a time load
        if (cnt_q == CNT_W'(SNOOZE_SEC - 1)) ast_d = AL_TRIG;
        else cnt_d = cnt_q + 1'b1;
      end
`endif
      else if (tchg_q && (ast_q == AL_ARMED) && (time_q == atime_q)) begin
        // Only a freshly written time value fires, so arming on a match waits
        ast_d = AL_TRIG;
      end
    end

    // Alarm channel registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        atime_q <= '0;
        ast_q   <= AL_OFF;
`ifdef ALARM_SNOOZE_EN
        cnt_q   <= '0;
`endif
      end else begin
        atime_q <= atime_d;
        ast_q   <= ast_d;
`ifdef ALARM_SNOOZE_EN
        cnt_q   <= cnt_d;
`endif
      end
    end

    assign di_alarm[16*gi +: 16]  = atime_q;
    assign alarm_state[2*gi +: 2] = ast_q;
    assign trig_vec[gi]           = (ast_q == AL_TRIG);
  end

  assign alarm_any_trig = |trig_vec;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Scoreboard bench for alarm_clock_multi (NUM_ALARMS=2, SNOOZE_SEC=3).
// Stimulus pushes hand-computed expected snapshots; a monitor pops one on
// every cmd_done / cmd_err pulse or explicit snapshot request.
module tb_alarm_clock_multi;

  localparam int NA = 2;
  localparam int K_SNAP = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        oneSecStrb = 1'b0;
  logic        bu_rx_data_rdy = 1'b0;
  logic [7:0]  bu_rx_data = 8'h00;
  logic [3:0]  di_Mtens, di_Mones, di_Stens, di_Sones;
  logic [16*NA-1:0] di_alarm;
  logic [2*NA-1:0]  alarm_state;
  logic        alarm_any_trig, cmd_busy, cmd_done, cmd_err;
  logic        snap_req = 1'b0;

  always #5 clk = ~clk;

  alarm_clock_multi #(.NUM_ALARMS(NA), .SNOOZE_SEC(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .oneSecStrb     (oneSecStrb),
    .bu_rx_data_rdy (bu_rx_data_rdy),
    .bu_rx_data     (bu_rx_data),
    .di_Mtens       (di_Mtens),
    .di_Mones       (di_Mones),
    .di_Stens       (di_Stens),
    .di_Sones       (di_Sones),
    .di_alarm       (di_alarm),
    .alarm_state    (alarm_state),
    .alarm_any_trig (alarm_any_trig),
    .cmd_busy       (cmd_busy),
    .cmd_done       (cmd_done),
    .cmd_err        (cmd_err)
  );

  typedef struct {
    int          kind;
    logic [15:0] t;
    logic [31:0] al;
    logic [3:0]  st;
    logic        trig;
    logic        busy;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Hand-maintained expected view of the DUT
  logic [15:0] m_t = 16'h0000;
  logic [31:0] m_al = 32'h0;
  logic [3:0]  m_st = 4'b0000;
  logic        m_trig = 1'b0;

  task automatic push(input int kind, input logic busy, input string name);
    exp_t e;
    e.kind = kind; e.t = m_t; e.al = m_al; e.st = m_st;
    e.trig = m_trig; e.busy = busy; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r, input logic [7:0] d, input bit s);
    bu_rx_data_rdy = r;
    bu_rx_data     = d;
    oneSecStrb     = s;
    @(posedge clk);
    #1;
    bu_rx_data_rdy = 1'b0;
    oneSecStrb     = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) drive(1'b1, s[i], 1'b0);
  endtask

  task automatic cr();
    drive(1'b1, 8'h0D, 1'b0);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic snap(input logic busy, input string name);
    push(K_SNAP, busy, name);
    snap_req = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    snap_req = 1'b0;
  endtask

  // Monitor: compare the next expectation whenever the DUT reports
  exp_t        e_mon;
  int          akind;
  logic [15:0] at;
  always @(negedge clk) begin
    if (cmd_done || cmd_err || snap_req) begin
      akind = cmd_done ? K_DONE : (cmd_err ? K_ERR : K_SNAP);
      at    = {di_Mtens, di_Mones, di_Stens, di_Sones};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got kind=%0d t=%h, required no event", akind, at);
      end else begin
        e_mon = exp_q.pop_front();
        if (akind != e_mon.kind || at !== e_mon.t || di_alarm !== e_mon.al ||
            alarm_state !== e_mon.st || alarm_any_trig !== e_mon.trig ||
            cmd_busy !== e_mon.busy) begin
          n_bad++;
          $display("FAIL %s: got kind=%0d t=%h al=%h st=%b trig=%b busy=%b, required kind=%0d t=%h al=%h st=%b trig=%b busy=%b",
                   e_mon.name, akind, at, di_alarm, alarm_state, alarm_any_trig, cmd_busy,
                   e_mon.kind, e_mon.t, e_mon.al, e_mon.st, e_mon.trig, e_mon.busy);
        end else begin
          $display("ok   %s: kind=%0d t=%h al=%h st=%b", e_mon.name, akind, at, di_alarm, alarm_state);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    snap(1'b0, "in_reset");
    rst_n = 1'b1;
    idle(2);
    snap(1'b0, "after_reset");

    // Time load then roll over 59:59
    send_str("l5958"); m_t = 16'h5958; push(K_DONE, 1'b0, "load_5958"); cr();
    strobes(3); m_t = 16'h0001;
    snap(1'b0, "wrap_to_0001");

    // Alarm 1 at 00:03, armed, fires the cycle after 00:03 appears
    send_str("a10003"); m_al = 32'h0003_0000; push(K_DONE, 1'b0, "load_alarm1"); cr();
    send_str("@1"); m_st = 4'b0100; push(K_DONE, 1'b0, "arm_alarm1"); cr();
    send_str("l0000"); m_t = 16'h0000; push(K_DONE, 1'b0, "load_0000"); cr();
    strobes(3); m_t = 16'h0003;
    snap(1'b0, "at_0003_still_armed");
    m_st = 4'b1000; m_trig = 1'b1;
    snap(1'b0, "alarm1_trig");

    // Bad bytes abort; unknown bytes in IDLE are ignored
    send_str("l"); push(K_ERR, 1'b0, "bad_tens_6"); send_str("6");
    send_str("a"); push(K_ERR, 1'b0, "bad_index_9"); send_str("9");
    cr(); send_str("x"); idle(2);
    snap(1'b0, "idle_ignores_junk");
`ifndef ALARM_SNOOZE_EN
    send_str("s"); cr(); idle(1);
    snap(1'b0, "s_ignored_no_snooze");
`endif

    // Clock frozen while time digits are being typed
    send_str("l12"); strobes(5);
    snap(1'b1, "frozen_during_load");
    send_str("34"); m_t = 16'h1234; push(K_DONE, 1'b0, "load_1234"); cr();
    strobes(1); m_t = 16'h1235;
    snap(1'b0, "clock_resumes");

    // Load and tick in the same cycle: the load wins
    send_str("l2000"); m_t = 16'h2000; push(K_DONE, 1'b0, "load_beats_tick");
    drive(1'b1, 8'h0D, 1'b1);
    idle(1);
    snap(1'b0, "no_tick_after_load");

    // Toggle a TRIG alarm off
    send_str("@1"); m_st = 4'b0000; m_trig = 1'b0; push(K_DONE, 1'b0, "disarm_trig1"); cr();

    // Arming on an already-matching time does not fire
    send_str("a02000"); m_al = 32'h0003_2000; push(K_DONE, 1'b0, "load_alarm0"); cr();
    send_str("@0"); m_st = 4'b0001; push(K_DONE, 1'b0, "arm0_on_match"); cr();
    idle(3);
    snap(1'b0, "no_trig_on_arm_match");
    send_str("a01000"); m_al = 32'h0003_1000; push(K_DONE, 1'b0, "reload_keeps_state"); cr();

    // Aborts change nothing visible
    send_str("l1111"); push(K_ERR, 1'b0, "eol_not_cr"); send_str("x");
    send_str("a0"); push(K_ERR, 1'b0, "alarm_digit_bad"); send_str("9");
    idle(1);
    snap(1'b0, "abort_no_change");

    // Asynchronous reset mid-command
    send_str("l12");
    rst_n = 1'b0;
    m_t = 16'h0000; m_al = 32'h0; m_st = 4'b0000; m_trig = 1'b0;
    snap(1'b0, "async_reset_mid_cmd");
    rst_n = 1'b1;
    idle(1);
    send_str("34"); cr(); idle(2);
    snap(1'b0, "partial_cmd_discarded");

`ifdef ALARM_SNOOZE_EN
    // Snooze: TRIG -> SNOOZED -> TRIG after 3 strobes, toggle from SNOOZED -> OFF
    send_str("a00003"); m_al = 32'h0000_0003; push(K_DONE, 1'b0, "load_alarm0_sn"); cr();
    send_str("@0"); m_st = 4'b0001; push(K_DONE, 1'b0, "arm0_sn"); cr();
    strobes(3); idle(1); m_t = 16'h0003; m_st = 4'b0010; m_trig = 1'b1;
    snap(1'b0, "alarm0_trig");
    send_str("s"); m_st = 4'b0011; m_trig = 1'b0; push(K_DONE, 1'b0, "snooze"); cr();
    strobes(2); idle(1); m_t = 16'h0005;
    snap(1'b0, "snoozing");
    strobes(1); idle(1); m_t = 16'h0006; m_st = 4'b0010; m_trig = 1'b1;
    snap(1'b0, "snooze_expired");
    send_str("s"); m_st = 4'b0011; m_trig = 1'b0; push(K_DONE, 1'b0, "resnooze"); cr();
    send_str("@0"); m_st = 4'b0000; push(K_DONE, 1'b0, "snoozed_to_off"); cr();
`endif

    idle(3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
